// File: rtl/tt_um_hoene_led_pkg.sv
// Shared defaults and state type for the LED brightness fader.
// Optional gamma stage selected by TT_UM_HOENE_FADER_GAMMA_EN.
package tt_um_hoene_led_pkg;

   localparam int unsigned FADER_WIDTH = 10;
   localparam int unsigned FADER_DIV   = 64;

   typedef enum logic {
      IDLE = 1'b0,
      FADE = 1'b1
   } fader_state_e;

endpackage

// File: rtl/tt_um_hoene_fader_channel.sv
// One colour channel: target and output registers plus the +/-1 step.
// Optional gamma stage selected by TT_UM_HOENE_FADER_GAMMA_EN.
module tt_um_hoene_fader_channel
   import tt_um_hoene_led_pkg::*;
#(
   parameter int unsigned WIDTH = FADER_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             store_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] tgt_i,
   output logic [WIDTH-1:0] out_o,
   output logic             differs_o,
   output logic             at_target_o
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] tgt_q;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;

   always_comb begin
      out_d = out_q;
      if (step_i) begin
         if (out_q < tgt_q)
            out_d = out_q + ONE;
         else if (out_q > tgt_q)
            out_d = out_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt_q <= '0;
         out_q <= '0;
      end else begin
         if (store_i)
            tgt_q <= tgt_i;
         out_q <= out_d;
      end
   end

   // at_target looks at the post-step value so busy drops on the final step
   assign at_target_o = (out_d == tgt_q);
   assign differs_o   = (tgt_i != out_q);
   assign out_o       = out_q;

endmodule

// File: rtl/tt_um_hoene_led_fader.sv
// Three-channel LED fader: prescaler, IDLE/FADE state and optional gamma.
// Optional gamma stage selected by TT_UM_HOENE_FADER_GAMMA_EN.
module tt_um_hoene_led_fader
   import tt_um_hoene_led_pkg::*;
#(
   parameter int unsigned WIDTH = FADER_WIDTH,
   parameter int unsigned DIV   = FADER_DIV
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_red,
   input  logic [WIDTH-1:0] in_green,
   input  logic [WIDTH-1:0] in_blue,
   input  logic             in_store,
   output logic [WIDTH-1:0] out_red,
   output logic [WIDTH-1:0] out_green,
   output logic [WIDTH-1:0] out_blue,
   output logic             out_busy
);

   localparam logic [15:0] LAST = 16'(DIV - 1);

   fader_state_e     state_q;
   logic [15:0]      presc_q;
   logic             busy_q;
   logic             step;
   logic             any_diff;
   logic             all_at;
   logic [2:0]       diff;
   logic [2:0]       at;
   logic [WIDTH-1:0] lin_r, lin_g, lin_b;

   assign step     = (state_q == FADE) && (presc_q == LAST) && !in_store;
   assign any_diff = |diff;
   assign all_at   = &at;

   tt_um_hoene_fader_channel #(.WIDTH(WIDTH)) u_red (
      .clk(clk), .rst_n(rst_n),
      .store_i(in_store), .step_i(step),
      .tgt_i(in_red), .out_o(lin_r),
      .differs_o(diff[0]), .at_target_o(at[0])
   );

   tt_um_hoene_fader_channel #(.WIDTH(WIDTH)) u_green (
      .clk(clk), .rst_n(rst_n),
      .store_i(in_store), .step_i(step),
      .tgt_i(in_green), .out_o(lin_g),
      .differs_o(diff[1]), .at_target_o(at[1])
   );

   tt_um_hoene_fader_channel #(.WIDTH(WIDTH)) u_blue (
      .clk(clk), .rst_n(rst_n),
      .store_i(in_store), .step_i(step),
      .tgt_i(in_blue), .out_o(lin_b),
      .differs_o(diff[2]), .at_target_o(at[2])
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         presc_q <= '0;
         busy_q  <= 1'b0;
      end else if (in_store) begin
         presc_q <= '0;
         state_q <= any_diff ? FADE : IDLE;
         busy_q  <= any_diff;
      end else if (state_q == FADE) begin
         if (presc_q == LAST) begin
            presc_q <= '0;
            if (all_at) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         end else begin
            presc_q <= presc_q + 16'd1;
         end
      end
   end

   assign out_busy = busy_q;

`ifdef TT_UM_HOENE_FADER_GAMMA_EN
   localparam int unsigned W2 = 2 * WIDTH;

   logic [W2-1:0]    sq_r, sq_g, sq_b;
   logic [WIDTH-1:0] gam_r_q, gam_g_q, gam_b_q;

   assign sq_r = W2'(lin_r) * W2'(lin_r);
   assign sq_g = W2'(lin_g) * W2'(lin_g);
   assign sq_b = W2'(lin_b) * W2'(lin_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gam_r_q <= '0;
         gam_g_q <= '0;
         gam_b_q <= '0;
      end else begin
         gam_r_q <= sq_r[W2-1:WIDTH];
         gam_g_q <= sq_g[W2-1:WIDTH];
         gam_b_q <= sq_b[W2-1:WIDTH];
      end
   end

   assign out_red   = gam_r_q;
   assign out_green = gam_g_q;
   assign out_blue  = gam_b_q;
`else
   assign out_red   = lin_r;
   assign out_green = lin_g;
   assign out_blue  = lin_b;
`endif

endmodule

// File: tb/tb_tt_um_hoene_led_fader.sv
// Directed bench for the LED fader, with an elapsed-time reference model.
// Targets the default build (TT_UM_HOENE_FADER_GAMMA_EN undefined).
module tb_tt_um_hoene_led_fader;

   localparam int W   = 10;
   localparam int DIV = 4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] in_red, in_green, in_blue;
   logic         in_store;
   logic [W-1:0] out_red, out_green, out_blue;
   logic         out_busy;

   int total;
   int bad;

   tt_um_hoene_led_fader #(.WIDTH(W), .DIV(DIV)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
      .in_store(in_store),
      .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
      .out_busy(out_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: cycles elapsed since the last store decide when a step lands.
   int m_tgt [3];
   int m_out [3];
   int m_since;
   bit m_busy;

   function automatic bit m_any_diff();
      bit d = 0;
      for (int c = 0; c < 3; c++)
         if (m_tgt[c] != m_out[c]) d = 1;
      return d;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 3; c++) begin
            m_tgt[c] = 0;
            m_out[c] = 0;
         end
         m_since = 0;
         m_busy  = 0;
      end else if (in_store) begin
         m_tgt[0] = int'(in_red);
         m_tgt[1] = int'(in_green);
         m_tgt[2] = int'(in_blue);
         m_since  = 0;
         m_busy   = m_any_diff();
      end else if (m_busy) begin
         m_since++;
         if (m_since % DIV == 0) begin
            for (int c = 0; c < 3; c++) begin
               if (m_out[c] < m_tgt[c]) m_out[c]++;
               else if (m_out[c] > m_tgt[c]) m_out[c]--;
            end
            m_busy = m_any_diff();
         end
      end
   end

   always @(negedge clk) begin
      total++;
      if (int'(out_red) != m_out[0] || int'(out_green) != m_out[1] ||
          int'(out_blue) != m_out[2] || out_busy != m_busy) begin
         bad++;
         $display("FAIL model t=%0t got=(%0d,%0d,%0d,%0b) want=(%0d,%0d,%0d,%0b)",
                  $time, out_red, out_green, out_blue, out_busy,
                  m_out[0], m_out[1], m_out[2], m_busy);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic chk_rgb(input string name, input int r, input int g,
                          input int b, input int busy);
      chk({name, ".r"}, int'(out_red), r);
      chk({name, ".g"}, int'(out_green), g);
      chk({name, ".b"}, int'(out_blue), b);
      chk({name, ".busy"}, int'(out_busy), busy);
   endtask

   // Called 1 time unit after a rising edge; store sampled at the next edge.
   task automatic store(input int r, input int g, input int b);
      in_red   = W'(r);
      in_green = W'(g);
      in_blue  = W'(b);
      in_store = 1'b1;
      @(posedge clk);
      #1;
      in_store = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      in_red   = '0;
      in_green = '0;
      in_blue  = '0;
      in_store = 1'b0;
      rst_n    = 1'b0;
      cyc(3);
      chk_rgb("reset", 0, 0, 0, 0);
      rst_n = 1'b1;
      cyc(1);

      store(3, 0, 0);
      chk_rgb("up.e0", 0, 0, 0, 1);
      cyc(3);
      chk("up.e3", int'(out_red), 0);
      cyc(1);
      chk("up.e4", int'(out_red), 1);
      cyc(4);
      chk("up.e8", int'(out_red), 2);
      cyc(3);
      chk("up.e11.busy", int'(out_busy), 1);
      cyc(1);
      chk_rgb("up.e12", 3, 0, 0, 0);

      store(0, 2, 1);
      cyc(4);
      chk_rgb("mix.s1", 2, 1, 1, 1);
      cyc(4);
      chk_rgb("mix.s2", 1, 2, 1, 1);
      cyc(4);
      chk_rgb("mix.s3", 0, 2, 1, 0);

      store(0, 2, 1);
      chk_rgb("same.e0", 0, 2, 1, 0);
      cyc(8);
      chk_rgb("same.e8", 0, 2, 1, 0);

      store(0, 0, 0);
      cyc(8);
      chk_rgb("zero", 0, 0, 0, 0);

      store(10, 0, 0);
      cyc(8);
      chk("rt.first", int'(out_red), 2);
      cyc(2);
      store(0, 0, 0);
      chk_rgb("rt.e0", 2, 0, 0, 1);
      cyc(3);
      chk("rt.e3", int'(out_red), 2);
      cyc(1);
      chk("rt.e4", int'(out_red), 1);
      cyc(4);
      chk_rgb("rt.e8", 0, 0, 0, 0);

      // second store lands on the edge that would have stepped
      store(8, 0, 0);
      cyc(3);
      store(8, 0, 0);
      chk_rgb("sw.e0", 0, 0, 0, 1);
      cyc(3);
      chk("sw.e3", int'(out_red), 0);
      cyc(1);
      chk("sw.e4", int'(out_red), 1);
      cyc(16);
      chk_rgb("ar.pre", 5, 0, 0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_rgb("ar.async", 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1);
      chk_rgb("ar.post", 0, 0, 0, 0);

      store(1023, 1023, 1023);
      cyc(4091);
      chk_rgb("max.pre", 1022, 1022, 1022, 1);
      cyc(1);
      chk_rgb("max.end", 1023, 1023, 1023, 0);
      cyc(8);
      chk_rgb("max.hold", 1023, 1023, 1023, 0);
      store(1023, 1023, 1023);
      cyc(4);
      chk_rgb("max.again", 1023, 1023, 1023, 0);

      do_reset();
      cyc(1);
      chk_rgb("final.reset", 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tt_um_hoene_led_fader.md
# tt_um_hoene_led_fader

Per-channel brightness fader between the serial-to-parallel register and the LED PWM stage. It takes the three 10-bit colour values latched at the end of a frame and ramps its outputs one LSB per step toward them, so colour changes fade instead of jumping. The outputs feed the red, green and blue duty inputs of the PWM generator directly. A busy flag reports an active fade.

## Interface
- `WIDTH`, default 10: bits per colour channel.
- `DIV`, default 64: clock cycles per fade step. Legal range is 2..65535.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_red`, `in_green`, `in_blue`  in  WIDTH each  target values, taken from serial-to-parallel bits [9:0], [19:10] and [29:20].
- `in_store`  in  1  single-cycle strobe: the targets are valid on this cycle (pwm_set && !frame).
- `out_red`, `out_green`, `out_blue`  out  WIDTH each  current duty values to the PWM stage.
- `out_busy`  out  1  high while any output differs from its target.

## Operation
- State machine with two states, IDLE and FADE. Reset enters IDLE.
- Reset values:
  - every target register, every output and the prescaler are 0;
  - `out_busy` is 0.
- When `in_store` is sampled high:
  - the three targets are registered;
  - the prescaler is cleared to 0;
  - the state becomes FADE if any new target differs from its current output, otherwise IDLE.
- Prescaler behaviour:
  - in FADE it counts 0 to DIV-1 and wraps;
  - in IDLE it is held at 0.
- Step behaviour: on a cycle in FADE with prescaler == DIV-1, each channel moves independently:
  - output < target: output + 1;
  - output > target: output − 1;
  - output == target: unchanged.
- Arithmetic is unsigned. The step never overshoots and never wraps; 0 and 2^WIDTH−1 are reachable and are stable end points.
- When all three outputs equal their targets after a step, the state returns to IDLE.
- Retarget during FADE: a new `in_store` replaces the targets and restarts the prescaler. The outputs keep their current values and begin ramping toward the new targets.
- `in_store` on the same cycle as a step: the store wins. No step is applied on that cycle, and the prescaler is cleared.
- Reset asserted mid-fade: everything returns to the reset values immediately, asynchronously.
- `out_busy` is high exactly when the state is FADE.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Store sampled at edge E:
  - targets and `out_busy` are updated after E;
  - the first step is visible after edge E+DIV;
  - subsequent steps follow every DIV cycles.
- A full-scale fade (0 to 1023) ends 1023·DIV cycles after E, and `out_busy` drops on that same edge.
- A store whose targets equal the current outputs leaves `out_busy` at 0.

## Configuration
- `TT_UM_HOENE_FADER_GAMMA_EN` defined:
  - each output passes through a registered quadratic gamma stage, out = (v·v) >> WIDTH, where v is the linear fade value;
  - this adds one cycle of latency to every output change;
  - `out_busy` stays aligned to the linear value and is not delayed.
- Macro not defined: the outputs are the linear fade values, with no extra latency.

## Structure
- Shared package `tt_um_hoene_led_pkg` holds:
  - the `WIDTH` default;
  - the fader state enum (IDLE, FADE);
  - the default `DIV`.
- One sub-module, `tt_um_hoene_fader_channel`, instantiated three times. Each instance holds one target register, one output register, the ±1 step logic and an `at_target` flag.
- The top of the block owns:
  - the prescaler;
  - the state machine;
  - the AND of the three `at_target` flags;
  - the optional gamma stage.

## Test plan
All scenarios use DIV=4.
- Reset and up-ramp:
  - after reset, all outputs are 0 and `out_busy` = 0;
  - store red=3, green=0, blue=0 → red steps 1, 2, 3 at 4, 8 and 12 cycles after the store;
  - `out_busy` falls at cycle 12.
- Down-ramp and mixed directions: from outputs (3,0,0), store (0,2,1) →
  - after the first step: (2,1,1);
  - after the second step: (1,2,1);
  - after the third step: (0,2,1), and `out_busy` falls.
- No-change store: store the targets equal to the current outputs → `out_busy` stays 0 and the outputs are unchanged.
- Retarget mid-fade:
  - from outputs 0, store red=10;
  - after red reaches 2, store red=0 with prescaler at 2;
  - red then reaches 1 four cycles after the second store and 0 at eight cycles.
- Extremes: store 1023 on all channels from 0 → the outputs reach exactly 1023 after 4092 cycles and hold there; a further store of 1023 keeps them at 1023.
- Asynchronous reset mid-fade:
  - assert `rst_n`=0 between clock edges while red is 5 and fading;
  - the outputs read 0 and `out_busy` reads 0 before the next edge.
